// File: rtl/dif_stage_ctrl_if.sv
// dif_stage_ctrl_if: serial sample stream, butterfly pair/result streams and
// serial output stream of one DIF FFT stage controller.
// Optional start-of-frame pins (i_sof/o_sof) exist only when the macro
// DIF_STAGE_CTRL_SOF_EN is defined.
interface dif_stage_ctrl_if #(
   parameter int IN_W  = 10,
   parameter int OUT_W = IN_W + 1
);
   // serial input samples
   logic                    i_vld;
   logic signed [IN_W-1:0]  i_I;
   logic signed [IN_W-1:0]  i_Q;
   // sample pair toward the butterfly
   logic                    o_bf_vld;
   logic signed [IN_W-1:0]  o_bf_LI;
   logic signed [IN_W-1:0]  o_bf_LQ;
   logic signed [IN_W-1:0]  o_bf_RI;
   logic signed [IN_W-1:0]  o_bf_RQ;
   // butterfly results
   logic                    i_bf_vld;
   logic signed [OUT_W-1:0] i_bf_LI;
   logic signed [OUT_W-1:0] i_bf_LQ;
   logic signed [OUT_W-1:0] i_bf_RI;
   logic signed [OUT_W-1:0] i_bf_RQ;
   // serial output toward the next stage
   logic                    o_vld;
   logic signed [OUT_W-1:0] o_I;
   logic signed [OUT_W-1:0] o_Q;
   logic                    o_ovf_strb;
`ifdef DIF_STAGE_CTRL_SOF_EN
   logic                    i_sof;
   logic                    o_sof;

   modport slave (
      input  i_vld, i_I, i_Q, i_sof,
      output o_bf_vld, o_bf_LI, o_bf_LQ, o_bf_RI, o_bf_RQ,
      input  i_bf_vld, i_bf_LI, i_bf_LQ, i_bf_RI, i_bf_RQ,
      output o_vld, o_I, o_Q, o_ovf_strb, o_sof
   );
   modport master (
      output i_vld, i_I, i_Q, i_sof,
      input  o_bf_vld, o_bf_LI, o_bf_LQ, o_bf_RI, o_bf_RQ,
      output i_bf_vld, i_bf_LI, i_bf_LQ, i_bf_RI, i_bf_RQ,
      input  o_vld, o_I, o_Q, o_ovf_strb, o_sof
   );
`else
   modport slave (
      input  i_vld, i_I, i_Q,
      output o_bf_vld, o_bf_LI, o_bf_LQ, o_bf_RI, o_bf_RQ,
      input  i_bf_vld, i_bf_LI, i_bf_LQ, i_bf_RI, i_bf_RQ,
      output o_vld, o_I, o_Q, o_ovf_strb
   );
   modport master (
      output i_vld, i_I, i_Q,
      input  o_bf_vld, o_bf_LI, o_bf_LQ, o_bf_RI, o_bf_RQ,
      output i_bf_vld, i_bf_LI, i_bf_LQ, i_bf_RI, i_bf_RQ,
      input  o_vld, o_I, o_Q, o_ovf_strb
   );
`endif
endinterface

// File: rtl/dif_stage_ctrl.sv
// dif_stage_ctrl: data reordering around one radix-2 DIF butterfly.
// The first N/2 samples of a frame are parked in the L buffer; each of the
// last N/2 samples is paired with its L partner and sent to the butterfly.
// Butterfly L results stream straight out, R results are parked in the R
// buffer and drained afterwards, giving L0..L(N/2-1), R0..R(N/2-1) order.
// Optional feature macro: DIF_STAGE_CTRL_SOF_EN adds i_sof/o_sof frame marks.
module dif_stage_ctrl #(
   parameter int IN_W         = 10,
   parameter int OUT_W        = IN_W + 1,
   parameter int STAGE        = 0,
   parameter int TOTAL_STAGES = 8
) (
   input  logic            mclk,
   input  logic            i_init,
   dif_stage_ctrl_if.slave bus
);
   localparam int CW   = TOTAL_STAGES - STAGE;      // log2(N)
   localparam int N    = 2 ** CW;
   localparam int HALF = N / 2;
   localparam int AW   = (CW > 1) ? CW - 1 : 1;     // buffer address / out_cnt width

   localparam logic [CW-1:0] IN_ONE       = CW'(1'b1);
   localparam logic [CW-1:0] IN_HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] IN_LAST      = CW'(N - 1);
   localparam logic [AW-1:0] ADDR_MASK    = AW'(HALF - 1);
   localparam logic [AW-1:0] OUT_ONE      = AW'(1'b1);
   localparam logic [AW-1:0] OUT_LAST     = AW'(HALF - 1);

   typedef enum logic {FILL = 1'b0, PAIR  = 1'b1} in_state_t;
   typedef enum logic {PASS = 1'b0, DRAIN = 1'b1} out_state_t;

   // input side
   in_state_t               in_state, in_state_nxt, eff_state;
   logic [CW-1:0]           in_cnt, in_cnt_nxt, eff_cnt;
   logic                    sof_hit;
   logic                    l_wr, bf_load;
   logic [AW-1:0]           l_addr;
   logic signed [IN_W-1:0]  l_buf_i [HALF];
   logic signed [IN_W-1:0]  l_buf_q [HALF];

   // output side
   out_state_t              out_state, out_state_nxt;
   logic [AW-1:0]           out_cnt, out_cnt_nxt;
   logic                    pass_hit, drain_act, ovf_hit;
   logic signed [OUT_W-1:0] r_buf_i [HALF];
   logic signed [OUT_W-1:0] r_buf_q [HALF];

`ifdef DIF_STAGE_CTRL_SOF_EN
   assign sof_hit = bus.i_vld & bus.i_sof;
`else
   assign sof_hit = 1'b0;
`endif

   // A start-of-frame sample is treated as sample 0 of a fresh frame.
   always_comb begin
      eff_cnt   = in_cnt;
      eff_state = in_state;
      if (sof_hit) begin
         eff_cnt   = {CW{1'b0}};
         eff_state = FILL;
      end else begin
         eff_cnt   = in_cnt;
         eff_state = in_state;
      end
   end

   // Input FSM and sample counter register.
   always_ff @(posedge mclk or posedge i_init) begin
      if (i_init) begin
         in_state <= FILL;
         in_cnt   <= {CW{1'b0}};
      end else begin
         in_state <= in_state_nxt;
         in_cnt   <= in_cnt_nxt;
      end
   end

   // Input next state: counter wraps N-1 -> 0 with no idle cycle.
   always_comb begin
      in_state_nxt = in_state;
      in_cnt_nxt   = in_cnt;
      if (bus.i_vld) begin
         in_cnt_nxt = eff_cnt + IN_ONE;
         case (eff_state)
            FILL:    in_state_nxt = (eff_cnt == IN_HALF_LAST) ? PAIR : FILL;
            PAIR:    in_state_nxt = (eff_cnt == IN_LAST) ? FILL : PAIR;
            default: in_state_nxt = FILL;
         endcase
      end else begin
         in_state_nxt = in_state;
         in_cnt_nxt   = in_cnt;
      end
   end

   // Input FSM outputs: L buffer write in FILL, pair launch in PAIR.
   always_comb begin
      l_addr  = AW'(eff_cnt) & ADDR_MASK;
      l_wr    = 1'b0;
      bf_load = 1'b0;
      case (eff_state)
         FILL:    l_wr    = bus.i_vld;
         PAIR:    bf_load = bus.i_vld;
         default: begin
            l_wr    = 1'b0;
            bf_load = 1'b0;
         end
      endcase
   end

   // L buffer storage; contents survive reset on purpose.
   always_ff @(posedge mclk) begin
      if (l_wr) begin
         l_buf_i[l_addr] <= bus.i_I;
         l_buf_q[l_addr] <= bus.i_Q;
      end
   end

   // Pair register toward the butterfly; data holds while no pair is launched.
   always_ff @(posedge mclk or posedge i_init) begin
      if (i_init) begin
         bus.o_bf_vld <= 1'b0;
         bus.o_bf_LI  <= {IN_W{1'b0}};
         bus.o_bf_LQ  <= {IN_W{1'b0}};
         bus.o_bf_RI  <= {IN_W{1'b0}};
         bus.o_bf_RQ  <= {IN_W{1'b0}};
      end else begin
         bus.o_bf_vld <= bf_load;
         if (bf_load) begin
            bus.o_bf_LI <= l_buf_i[l_addr];
            bus.o_bf_LQ <= l_buf_q[l_addr];
            bus.o_bf_RI <= bus.i_I;
            bus.o_bf_RQ <= bus.i_Q;
         end
      end
   end

   // Output FSM and R-index counter register.
   always_ff @(posedge mclk or posedge i_init) begin
      if (i_init) begin
         out_state <= PASS;
         out_cnt   <= {AW{1'b0}};
      end else begin
         out_state <= out_state_nxt;
         out_cnt   <= out_cnt_nxt;
      end
   end

   // Output next state: PASS counts butterfly results, DRAIN walks the R buffer.
   always_comb begin
      out_state_nxt = out_state;
      out_cnt_nxt   = out_cnt;
      case (out_state)
         PASS: begin
            if (bus.i_bf_vld) begin
               if (out_cnt == OUT_LAST) begin
                  out_state_nxt = DRAIN;
                  out_cnt_nxt   = {AW{1'b0}};
               end else begin
                  out_cnt_nxt   = out_cnt + OUT_ONE;
               end
            end else begin
               out_cnt_nxt = out_cnt;
            end
         end
         DRAIN: begin
            if (out_cnt == OUT_LAST) begin
               out_state_nxt = PASS;
               out_cnt_nxt   = {AW{1'b0}};
            end else begin
               out_cnt_nxt   = out_cnt + OUT_ONE;
            end
         end
         default: begin
            out_state_nxt = PASS;
            out_cnt_nxt   = {AW{1'b0}};
         end
      endcase
   end

   // Output FSM outputs; a result arriving while draining is a collision.
   always_comb begin
      pass_hit  = 1'b0;
      drain_act = 1'b0;
      ovf_hit   = 1'b0;
      case (out_state)
         PASS:    pass_hit = bus.i_bf_vld;
         DRAIN: begin
            drain_act = 1'b1;
            ovf_hit   = bus.i_bf_vld;
         end
         default: begin
            pass_hit  = 1'b0;
            drain_act = 1'b0;
            ovf_hit   = 1'b0;
         end
      endcase
   end

   // R buffer storage; dropped results never reach it.
   always_ff @(posedge mclk) begin
      if (pass_hit) begin
         r_buf_i[out_cnt] <= bus.i_bf_RI;
         r_buf_q[out_cnt] <= bus.i_bf_RQ;
      end
   end

   // Serial output register: L results pass through, then R entries drain.
   always_ff @(posedge mclk or posedge i_init) begin
      if (i_init) begin
         bus.o_vld      <= 1'b0;
         bus.o_I        <= {OUT_W{1'b0}};
         bus.o_Q        <= {OUT_W{1'b0}};
         bus.o_ovf_strb <= 1'b0;
`ifdef DIF_STAGE_CTRL_SOF_EN
         bus.o_sof      <= 1'b0;
`endif
      end else begin
         bus.o_vld      <= pass_hit | drain_act;
         bus.o_ovf_strb <= ovf_hit;
`ifdef DIF_STAGE_CTRL_SOF_EN
         bus.o_sof      <= pass_hit & (out_cnt == {AW{1'b0}});
`endif
         if (pass_hit) begin
            bus.o_I <= bus.i_bf_LI;
            bus.o_Q <= bus.i_bf_LQ;
         end else if (drain_act) begin
            bus.o_I <= r_buf_i[out_cnt];
            bus.o_Q <= r_buf_q[out_cnt];
         end
      end
   end
endmodule

// File: doc/dif_stage_ctrl.md
DIF_STAGE_CTRL -- requirements
Module: dif_stage_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 10, the serial input sample width per I/Q rail.
REQ-002 SHALL have parameter OUT_W, default IN_W+1, the butterfly result width per rail.
REQ-003 SHALL have parameters STAGE (default 0) and TOTAL_STAGES (default 8); localparam N = 2**(TOTAL_STAGES-STAGE), with N >= 2.
REQ-004 SHALL have port: mclk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port: i_init  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: i_vld in 1, i_I in IN_W, i_Q in IN_W  signed serial input stream, one sample per valid cycle.
REQ-007 SHALL have ports: o_bf_vld out 1, o_bf_LI/o_bf_LQ/o_bf_RI/o_bf_RQ out IN_W each  signed sample pair to the butterfly.
REQ-008 SHALL have ports: i_bf_vld in 1, i_bf_LI/i_bf_LQ/i_bf_RI/i_bf_RQ in OUT_W each  signed butterfly results.
REQ-009 SHALL have ports: o_vld out 1, o_I/o_Q out OUT_W each  signed serial output stream for the next stage.
REQ-010 SHALL have port: o_ovf_strb out 1  one-cycle pulse on an R-buffer collision.

Function
REQ-011 SHALL keep input counter in_cnt (log2(N) bits) incremented once per i_vld and wrapping N-1 to 0 with no gap cycle.
REQ-012 SHALL run input FSM FILL (in_cnt < N/2) and PAIR (in_cnt >= N/2); FILL->PAIR on the valid with in_cnt = N/2-1; PAIR->FILL on the valid with in_cnt = N-1.
REQ-013 In FILL, SHALL write each valid sample to the L buffer (depth N/2, complex) at address in_cnt and SHALL NOT assert o_bf_vld.
REQ-014 In PAIR, SHALL read L buffer address in_cnt-N/2 and present it as L with the current sample as R, with o_bf_vld high exactly one cycle after the accepting i_vld.
REQ-015 o_bf_* data SHALL hold its last value when o_bf_vld is low.
REQ-016 SHALL run output FSM PASS and DRAIN with counter out_cnt (log2(N)-1 bits, width 1 when N = 2).
REQ-017 In PASS, each i_bf_vld SHALL emit i_bf_LI/LQ on o_I/o_Q with o_vld one cycle later and write i_bf_RI/RQ to the R buffer (depth N/2) at out_cnt.
REQ-018 PASS->DRAIN SHALL occur on the i_bf_vld with out_cnt = N/2-1; DRAIN SHALL then emit R entries 0..N/2-1 on consecutive cycles, o_vld continuously high, ignoring i_vld.
REQ-019 DRAIN->PASS SHALL occur after the last R entry is emitted; out_cnt SHALL wrap to 0.
REQ-020 An i_bf_vld arriving during DRAIN SHALL be dropped, SHALL pulse o_ovf_strb for one cycle, and SHALL NOT disturb the drain or its counters.
REQ-021 Output order per frame SHALL be L0..L(N/2-1) then R0..R(N/2-1).
REQ-022 No arithmetic SHALL be performed; data SHALL pass bit-exact, no resize.
REQ-023 For N = 2, FILL/PAIR SHALL alternate every valid and the buffers SHALL be one entry each.

Reset
REQ-024 While i_init is high: in_cnt = 0, out_cnt = 0, FILL, PASS, o_bf_vld = 0, o_vld = 0, o_ovf_strb = 0, all o_bf_* and o_I/o_Q = 0.
REQ-025 Buffer contents SHALL NOT be reset; reset mid-frame SHALL discard the partial frame, and the first valid after release SHALL be sample 0 of a new frame.
REQ-026 No output valid SHALL assert in the cycle i_init deasserts.

Configuration
REQ-027 With macro DIF_STAGE_CTRL_SOF_EN defined, SHALL add input i_sof (1) and output o_sof (1).
REQ-028 With DIF_STAGE_CTRL_SOF_EN, i_vld&i_sof SHALL force that sample to in_cnt = 0 (state FILL) and discard the partial frame; o_sof SHALL be high with o_vld on each L0.
REQ-029 Without DIF_STAGE_CTRL_SOF_EN, neither port SHALL exist and in_cnt SHALL free-run from reset per REQ-011.

Verification (N = 8: TOTAL_STAGES = 3, STAGE = 0)
REQ-030 Continuous i_vld, i_I = 1..8, i_Q = 0 -> o_bf_vld high 4 cycles, after samples 5..8; pairs (L,R) = (1,5),(2,6),(3,7),(4,8).
REQ-031 Butterfly loopback modelled as 5-cycle delay, two frames back-to-back -> o_I sequence 1,2,3,4,5,6,7,8 per frame; o_ovf_strb never asserts.
REQ-032 Four i_bf_vld pulses, then a fifth injected in the 2nd DRAIN cycle -> that pulse dropped, one o_ovf_strb pulse, drain still emits R0..R3.
REQ-033 i_init asserted asynchronously after sample 6 -> all outputs 0 immediately; a new 8-sample frame after release pairs (1,5)..(4,8) of the new data.
REQ-034 i_vld gapped 1-on/2-off -> identical pairs and output order to REQ-031.
REQ-035 With DIF_STAGE_CTRL_SOF_EN, i_sof on the 3rd valid -> counter restarts; pairs form against that sample as L0; o_sof marks the first L output.
